// File: rtl/rca_pkg.sv
// Shared types and defaults for the registered ripple-carry adder.
// Consumers bundle the registered outputs with rca_result_t.
package rca_pkg;

  localparam int RCA_DEFAULT_WIDTH = 4;

  typedef struct packed {
    logic                         carry;
    logic                         ovf;
    logic [RCA_DEFAULT_WIDTH-1:0] sum;
  } rca_result_t;

  function automatic rca_result_t rca_pack(
    input logic                         carry,
    input logic                         ovf,
    input logic [RCA_DEFAULT_WIDTH-1:0] sum
  );
    rca_result_t r;
    r.carry = carry;
    r.ovf   = ovf;
    r.sum   = sum;
    return r;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_fa.sv
// One-bit full adder; a single link of the ripple chain.
// Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with registered sum, carry and
// signed overflow, qualified by a one-cycle valid.
module ripple_carry_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             OVF
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a   (A[i]),
      .b   (B[i]),
      .cin (c[i]),
      .sum (s[i]),
      .cout(c[i+1])
    );
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;
  logic             valid_q;

  // Data registers only move on accept, so idle-cycle X cannot leak in.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (in_valid) begin
      sum_d   = s;
      carry_d = c[WIDTH];
      ovf_d   = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= in_valid;
    end
  end

  assign SUM       = sum_q;
  assign CARRY     = carry_q;
  assign OVF       = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder at WIDTH=4 and WIDTH=1.
// Expected {OVF,CARRY,SUM} are queued at drive time and popped on output.
module tb_ripple_carry_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic       iv4, ci4, ov4, co4, of4;
  logic [3:0] a4, b4, s4;
  logic       iv1, ci1, ov1, co1, of1;
  logic [0:0] a1, b1, s1;

  ripple_carry_adder #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (iv4),
    .A        (a4),
    .B        (b4),
    .Cin      (ci4),
    .out_valid(ov4),
    .SUM      (s4),
    .CARRY    (co4),
    .OVF      (of4)
  );

  ripple_carry_adder #(.WIDTH(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (iv1),
    .A        (a1),
    .B        (b1),
    .Cin      (ci1),
    .out_valid(ov1),
    .SUM      (s1),
    .CARRY    (co1),
    .OVF      (of1)
  );

  int vectors     = 0;
  int miscompares = 0;

  // {ovf, carry, sum}
  logic [5:0] q4[$];
  logic [2:0] q1[$];
  logic [5:0] last4 = '0;
  logic [2:0] last1 = '0;

  function automatic logic [5:0] model4(
    input logic [3:0] a, input logic [3:0] b, input logic c
  );
    logic [4:0] t;
    logic       o;
    t = {1'b0, a} + {1'b0, b} + {4'b0, c};
    o = (a[3] == b[3]) && (t[3] != a[3]);
    return {o, t};
  endfunction

  function automatic logic [2:0] model1(
    input logic a, input logic b, input logic c
  );
    logic [1:0] t;
    logic       o;
    t = {1'b0, a} + {1'b0, b} + {1'b0, c};
    o = (a == b) && (t[0] != a);
    return {o, t};
  endfunction

  // Drive one cycle on both DUTs, queue expectations, settle after edge.
  task automatic step(
    input logic v4, input logic [3:0] a, input logic [3:0] b,
    input logic c, input logic v1, input logic x1,
    input logic y1, input logic z1
  );
    logic [5:0] e4;
    logic [2:0] e1;
    iv4 = v4; a4 = a; b4 = b; ci4 = c;
    iv1 = v1; a1 = x1; b1 = y1; ci1 = z1;
    if (v4 === 1'b1) begin
      e4 = model4(a, b, c);
      q4.push_back(e4);
      last4 = e4;
    end
    if (v1 === 1'b1) begin
      e1 = model1(x1, y1, z1);
      q1.push_back(e1);
      last1 = e1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reset_between_edges();
    #2 rst_n = 1'b0;
    #1;
    q4.delete();
    q1.delete();
    last4 = '0;
    last1 = '0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst_n = 1'b0;
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv4 = 1'b1;
      a4  = 4'($urandom);
      b4  = 4'($urandom);
      ci4 = 1'($urandom);
      @(posedge clk);
      #1;
      got = {of4, co4, s4};
      vectors++;
      if (got !== 6'b0 || ov4 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: got v=%b %b want v=0 000000", ov4, got);
      end
    end
    rst_n = 1'b1;
    step(1'b1, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    got = q4.pop_front();
    vectors++;
    if ({of4, co4, s4} !== got || ov4 !== 1'b1) begin
      miscompares++;
      $display("FAIL first_accept: got v=%b %b want v=1 %b",
               ov4, {of4, co4, s4}, got);
    end
    // In-flight op: valid presented, reset falls before its edge.
    iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
    drop_reset_between_edges();
    vectors++;
    if ({of4, co4, s4} !== 6'b0 || ov4 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b %b want v=0 000000",
               ov4, {of4, co4, s4});
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({of4, co4, s4} !== 6'b0 || ov4 !== 1'b0) begin
      miscompares++;
      $display("FAIL inflight_discard: got v=%b %b want v=0 000000",
               ov4, {of4, co4, s4});
    end
    iv4 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_sweep(input logic cin);
    logic [3:0] ops[5];
    logic [5:0] exp;
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0011;
    ops[3] = 4'b0100; ops[4] = 4'b1101;
    if (cin) ops[2] = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ops[i], ops[i], cin, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (q4.size() == 0) begin
        miscompares++;
        $display("FAIL sweep_cin%0d[%0d]: got empty queue want entry", cin, i);
      end else begin
        exp = q4.pop_front();
        if ({of4, co4, s4} !== exp || ov4 !== 1'b1) begin
          miscompares++;
          $display("FAIL sweep_cin%0d[%0d]: got v=%b %b want v=1 %b",
                   cin, i, ov4, {of4, co4, s4}, exp);
        end
      end
    end
  endtask

  task automatic test_full_ripple();
    logic [3:0] av[2];
    logic [5:0] want[2];
    av[0] = 4'b1111; want[0] = 6'b0_1_0000;
    av[1] = 4'b0111; want[1] = 6'b1_0_1000;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, av[i], 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      void'(q4.pop_front());
      vectors++;
      if ({of4, co4, s4} !== want[i] || ov4 !== 1'b1) begin
        miscompares++;
        $display("FAIL full_ripple[%0d]: got v=%b %b want v=1 %b",
                 i, ov4, {of4, co4, s4}, want[i]);
      end
    end
  endtask

  task automatic test_handshake();
    logic       vp[6];
    logic [5:0] exp;
    vp[0] = 1; vp[1] = 0; vp[2] = 1; vp[3] = 0; vp[4] = 0; vp[5] = 1;
    for (int i = 0; i < 6; i++) begin
      if (vp[i])
        step(1'b1, 4'(3 * i + 2), 4'(7 * i + 1), 1'(i),
             1'b0, 1'b0, 1'b0, 1'b0);
      else
        step(1'b0, 4'bx, 4'bz, 1'bx, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (ov4 !== vp[i]) begin
        miscompares++;
        $display("FAIL handshake_valid[%0d]: got %b want %b", i, ov4, vp[i]);
      end
      exp = vp[i] ? q4.pop_front() : last4;
      vectors++;
      if ({of4, co4, s4} !== exp) begin
        miscompares++;
        $display("FAIL handshake_data[%0d]: got %b want %b",
                 i, {of4, co4, s4}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'($urandom), 4'($urandom), 1'($urandom),
           1'b0, 1'b0, 1'b0, 1'b0);
      exp = q4.pop_front();
      vectors++;
      if ({of4, co4, s4} !== exp || ov4 !== 1'b1) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got v=%b %b want v=1 %b",
                 i, ov4, {of4, co4, s4}, exp);
      end
    end
  endtask

  task automatic test_random();
    logic       v4, v1;
    logic [5:0] e4;
    logic [2:0] e1;
    for (int i = 0; i < 1200; i++) begin
      if (i % 300 == 150) begin
        drop_reset_between_edges();
        vectors++;
        if ({ov4, of4, co4, s4, ov1, of1, co1, s1} !== 11'b0) begin
          miscompares++;
          $display("FAIL rand_reset[%0d]: got %b_%b want all zero",
                   i, {ov4, of4, co4, s4}, {ov1, of1, co1, s1});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      v4 = 1'($urandom);
      v1 = 1'($urandom);
      step(v4, 4'($urandom), 4'($urandom), 1'($urandom),
           v1, 1'($urandom), 1'($urandom), 1'($urandom));
      e4 = (v4 && q4.size() != 0) ? q4.pop_front() : last4;
      e1 = (v1 && q1.size() != 0) ? q1.pop_front() : last1;
      vectors++;
      if (ov4 !== v4 || {of4, co4, s4} !== e4) begin
        miscompares++;
        $display("FAIL rand_w4[%0d]: got v=%b %b want v=%b %b",
                 i, ov4, {of4, co4, s4}, v4, e4);
      end
      vectors++;
      if (ov1 !== v1 || {of1, co1, s1} !== e1) begin
        miscompares++;
        $display("FAIL rand_w1[%0d]: got v=%b %b want v=%b %b",
                 i, ov1, {of1, co1, s1}, v1, e1);
      end
    end
  endtask

  initial begin
    iv4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    iv1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_full_ripple();
    test_handshake();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
